// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream_rr
// Purpose  : Selects one of CHANNELS valid/ready input streams into a single
//            registered output stream. The channel is chosen either by a
//            fixed index (sel_i) or by round-robin arbitration.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    : data width per channel
//   CHANNELS : number of input channels (2..16)
//   SEL_W    : width of sel_i / out_chan_o, 2**SEL_W >= CHANNELS
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_data_i  in   packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid_i in   per-channel valid
//   in_ready_o out  per-channel ready, one-hot or zero
//   sel_i      in   channel index used in fixed mode
//   rr_mode_i  in   0 = fixed select, 1 = round-robin
//   out_data_o out  registered output word
//   out_valid_o out output word valid
//   out_ready_i in  downstream accepts the output word
//   out_chan_o out  channel that produced out_data_o
// ============================================================================
module mux_stream_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data_i,
  input  logic [CHANNELS-1:0]       in_valid_i,
  output logic [CHANNELS-1:0]       in_ready_o,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic                      rr_mode_i,
  output logic [WIDTH-1:0]          out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SEL_W-1:0]          out_chan_o
);

  // One extra bit so last_grant + k (k <= CHANNELS) never overflows.
  localparam int                  IDX_W     = SEL_W + 1;
  localparam logic [IDX_W-1:0]    C_NUM_CH  = IDX_W'(CHANNELS);
  localparam logic [CHANNELS-1:0] C_ONE     = CHANNELS'(1);
  localparam logic [SEL_W-1:0]    C_LAST_CH = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic [SEL_W-1:0] out_chan_q,   out_chan_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             can_accept;
  logic             fix_vld;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_gnt;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;

  // Single-entry output register: free when empty or being drained now.
  assign can_accept = !out_valid_q || out_ready_i;

  // Fixed mode: out-of-range indices never grant. The shift yields zero for
  // large sel_i anyway, the explicit compare keeps the intent obvious.
  assign fix_vld = ({1'b0, sel_i} < C_NUM_CH) &&
                   (|(in_valid_i & (C_ONE << sel_i)));

  // Round-robin scan starting just after the last granted channel, wrapping
  // modulo CHANNELS. The first valid channel found wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    rr_vld = 1'b0;
    rr_gnt = '0;
    idx    = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = {1'b0, last_grant_q} + IDX_W'(k);
      if (idx >= C_NUM_CH) begin
        idx = idx - C_NUM_CH;
      end
      if (!rr_vld && (|(in_valid_i & (C_ONE << idx)))) begin
        rr_vld = 1'b1;
        rr_gnt = idx[SEL_W-1:0];
      end
    end
  end

  assign gnt_vld = rr_mode_i ? rr_vld : fix_vld;
  assign gnt     = rr_mode_i ? rr_gnt : sel_i;

  // reset_n gates ready so nothing handshakes while the block is held in
  // reset, even though the emptied output register could otherwise accept.
  assign xfer       = reset_n && can_accept && gnt_vld;
  assign in_ready_o = xfer ? (C_ONE << gnt) : '0;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // A transfer overrides a drain in the same cycle, giving one word/clock.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_chan_d  = gnt;
      out_valid_d = 1'b1;
      if (rr_mode_i) begin
        last_grant_d = gnt;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // last_grant resets to the final channel so channel 0 is scanned first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      last_grant_q <= C_LAST_CH;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_chan_o  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_stream_rr
// Purpose  : Self-checking bench for mux_stream_rr (4-channel main instance,
//            3-channel instance for the out-of-range select case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_stream_rr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_chan3;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];   // {chan, data}

  always #5 clk = ~clk;

  mux_stream_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sel_i(sel), .rr_mode_i(rr_mode),
    .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_chan_o(out_chan)
  );

  mux_stream_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_data_i(in_data3), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .sel_i(sel3), .rr_mode_i(1'b0),
    .out_data_o(out_data3), .out_valid_o(out_valid3),
    .out_ready_i(1'b1), .out_chan_o(out_chan3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is matched against the scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got chan %0d data %0h want none", out_chan, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_chan, out_data} !== e) begin
          errors++;
          $display("FAIL sb_word got chan %0d data %0h want chan %0d data %0h",
                   out_chan, out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check ready/valid at posedge+3, then
  // optionally record the word expected to leave the output register.
  task automatic cyc(input logic [3:0] iv, input logic [31:0] d, input logic [1:0] s,
                     input logic rr, input logic ordy, input logic [3:0] exp_rdy,
                     input logic exp_ov, input logic push, input logic [7:0] ed,
                     input logic [1:0] ec, input string name);
    in_valid  = iv;
    in_data   = d;
    sel       = s;
    rr_mode   = rr;
    out_ready = ordy;
    #2;
    chk({name, "_in_ready"}, {28'd0, in_ready}, {28'd0, exp_rdy});
    chk({name, "_out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    if (push) sb.push_back({ec, ed});
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RRD = 32'h13121110;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    in_data   = RRD;
    sel       = 2'd0;
    rr_mode   = 1'b1;
    out_ready = 1'b1;
    in_data3  = 24'h332211;
    in_valid3 = 3'b000;
    sel3      = 2'd3;
    #3;
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_chan", {30'd0, out_chan}, 32'd0);
    chk("rst_in_ready3", {29'd0, in_ready3}, 32'd0);
    in_valid = 4'b0000;
    #19;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed mode, sel=2, sustained one word per clock
    cyc(4'b0110, 32'h00A53C00, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 8'hA5, 2'd2, "fix1");
    cyc(4'b0110, 32'h005A3C00, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h5A, 2'd2, "fix2");
    cyc(4'b0110, 32'h00C33C00, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 8'hC3, 2'd2, "fix3");

    // Fixed mode targeting an idle channel; 3-channel instance with sel=3
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    cyc(4'b0001, 32'h00000077, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, "fixinv1");
    chk("ch3_sel3_in_ready", {29'd0, in_ready3}, 32'd0);
    chk("ch3_sel3_out_valid", {31'd0, out_valid3}, 32'd0);
    sel3 = 2'd2;
    cyc(4'b0001, 32'h00000077, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, "fixinv2");
    chk("ch3_sel2_out_valid", {31'd0, out_valid3}, 32'd1);
    chk("ch3_sel2_out_data", {24'd0, out_data3}, 32'h33);
    chk("ch3_sel2_out_chan", {30'd0, out_chan3}, 32'd2);
    sel3      = 2'd3;
    in_valid3 = 3'b000;

    // Round-robin over all four channels, starting at channel 0
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 8'h10, 2'd0, "rr0");
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 2'd1, "rr1");
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h12, 2'd2, "rr2");
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h13, 2'd3, "rr3");
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h10, 2'd0, "rrwrap");

    // Back-pressure after word 0x11
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 2'd1, "bp_load");
    for (int n = 0; n < 5; n++) begin
      cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, "bp_stall");
      chk("bp_hold_data", {24'd0, out_data}, 32'h11);
      chk("bp_hold_chan", {30'd0, out_chan}, 32'd1);
    end
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h12, 2'd2, "bp_release");
    cyc(4'b0000, RRD, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, "drain1");

    // Bring last_grant to 1, then skip to 3 and wrap to 0
    cyc(4'b0010, RRD, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 8'h11, 2'd1, "skip_pre");
    cyc(4'b1001, RRD, 2'd0, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h13, 2'd3, "skip3");
    cyc(4'b1001, RRD, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h10, 2'd0, "skip0");
    cyc(4'b0000, RRD, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, "drain2");
    cyc(4'b0000, RRD, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, "idle");

    // Asynchronous reset while a word is stalled in the output register
    cyc(4'b0010, 32'h00003C00, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd0, "st_load");
    #2;
    chk("st_out_valid", {31'd0, out_valid}, 32'd1);
    chk("st_out_data", {24'd0, out_data}, 32'h3C);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_out_chan", {30'd0, out_chan}, 32'd0);
    chk("arst_in_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", {31'd0, out_valid}, 32'd0);
    reset_n = 1'b1;
    // Pointer restored: round-robin must start again at channel 0
    cyc(4'b1111, RRD, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 8'h10, 2'd0, "post_rst_rr");
    cyc(4'b0000, RRD, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, "drain3");
    cyc(4'b0000, RRD, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, "final_idle");

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised successor of the 2:1 word multiplexer used in the barrel shifter datapath.
- Selects one of CHANNELS input streams, each WIDTH bits wide, into a single registered output stream.
- Uses valid/ready handshaking on all streams.
- Two modes: fixed select (steered by sel) or round-robin arbitration.
- Sits between the shift/rotate stages and downstream consumers so multiple producers can share one shifter port.

Parameters:
- WIDTH, 8, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of sel and out_chan; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  packed input words; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- sel  input  SEL_W  channel index used when rr_mode=0.
- rr_mode  input  1  0 = fixed select, 1 = round-robin.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the output word.
- out_chan  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has highest priority first.
  - A word held in the output register is discarded; no in_ready is asserted while reset_n is low.
- Output register is a single entry:
  - can_accept = !out_valid || out_ready.
  - in_ready depends combinationally on out_ready; there is no skid buffer.
- Grant, evaluated combinationally each cycle:
  - rr_mode=0: grant=sel when sel<CHANNELS and in_valid[sel]=1; otherwise no grant. Any sel>=CHANNELS never grants.
  - rr_mode=1: grant is the first i with in_valid[i]=1, scanning last_grant+1, last_grant+2, … and wrapping modulo CHANNELS. If no channel is valid, there is no grant.
- in_ready[i] = can_accept && grant valid && (grant==i).
- Transfer: on a rising edge with in_valid[g] && in_ready[g]:
  - out_data <= channel g word, out_chan <= g, out_valid <= 1.
  - If rr_mode=1, last_grant <= g.
  - In fixed mode last_grant is unchanged.
- Drain: out_valid && out_ready with no new transfer -> out_valid <= 0. out_data and out_chan hold their last values.
- Drain and transfer in the same cycle: the new word replaces the old one; out_valid stays 1. This gives full throughput of one word per clock.
- Stall: out_valid && !out_ready -> out_data, out_chan and out_valid hold; all in_ready=0.
- Latency: 1 clock from input handshake to out_valid.
- Mode or sel change: takes effect in the same cycle's grant. A word already in the output register is unaffected.
- Producers must hold in_data and in_valid stable until ready. The block does not check this.
- Priority pointer wrap: last_grant=CHANNELS-1 wraps the scan to channel 0.

Test Plan:
- Reset with all inputs idle -> out_valid=0, out_data=0x00, in_ready=0000. Assert reset_n low mid-stall with out_valid=1 -> out_valid=0 immediately, no clock edge needed.
- Fixed mode: rr_mode=0, sel=2, in_valid=0110, ch2=0xA5, ch1=0x3C, out_ready=1 -> in_ready=0100; next cycle out_data=0xA5, out_chan=2. Repeating every cycle sustains out_valid=1 at one word per clock.
- Fixed mode, invalid target: sel=2, in_valid=0001 -> in_ready=0000, out_valid stays 0. sel=3 with CHANNELS=3 -> no grant regardless of in_valid.
- Round-robin: rr_mode=1, in_valid=1111 held, channel i word=0x10+i, out_ready=1 -> out_chan sequence 0,1,2,3,0; out_data 0x10,0x11,0x12,0x13,0x10.
- Back-pressure: out_ready=0 after first word 0x11 -> out_data=0x11 held, in_ready=0000 for 5 cycles. Raise out_ready -> the next word is accepted in the same cycle and out_valid never drops.
- Round-robin skip: last_grant=1, in_valid=1001 -> grant=3, then grant=0 (wrap). out_chan sequence 3,0.
